// File: rtl/skew_issue_ctrl.sv
// Feed/drain controller applying systolic skew into N_LANE delay lanes.
// Optional stall counter port enabled by SKEW_ISSUE_STALL_CNT_EN.
module skew_issue_ctrl #(
  parameter int N_LANE  = 4,
  parameter int DW_DATA = 32,
  parameter int W_LEN   = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [W_LEN-1:0]          len,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_LANE*DW_DATA-1:0] in_data,
  output logic [N_LANE-1:0]         lane_en,
  output logic [N_LANE*DW_DATA-1:0] lane_data,
  output logic                      busy,
  output logic                      done
`ifdef SKEW_ISSUE_STALL_CNT_EN
  ,
  output logic [W_LEN+7:0]          stall_cnt
`endif
);

  localparam int DCW = $clog2(N_LANE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [W_LEN-1:0] len_q;
  logic [W_LEN-1:0] cnt_q;
  logic [DCW-1:0]   dcnt_q;
  logic             zl_q;
  logic             acc_d;

  assign in_ready = (state_q == S_FEED);
  assign busy     = (state_q != S_IDLE);
  // zero-length blocks spend one extra DONE cycle before pulsing done
  assign done     = (state_q == S_DONE) && !zl_q;
  assign acc_d    = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      zl_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            len_q <= len;
            cnt_q <= '0;
            if (len == '0) begin
              state_q <= S_DONE;
              zl_q    <= 1'b1;
            end else begin
              state_q <= S_FEED;
            end
          end
        end
        S_FEED: begin
          if (in_valid) begin
            cnt_q <= cnt_q + W_LEN'(1);
            if (cnt_q == len_q - W_LEN'(1)) begin
              state_q <= S_DRAIN;
              dcnt_q  <= '0;
            end
          end
        end
        S_DRAIN: begin
          if (dcnt_q == DCW'(N_LANE - 1)) begin
            state_q <= S_DONE;
          end else begin
            dcnt_q <= dcnt_q + DCW'(1);
          end
        end
        S_DONE: begin
          if (zl_q) begin
            zl_q <= 1'b0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < N_LANE; g++) begin : g_lane
    logic               v_q [g+1];
    logic [DW_DATA-1:0] d_q [g+1];
    logic [DW_DATA-1:0] d_d;

    assign d_d = acc_d ? in_data[g*DW_DATA +: DW_DATA] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int k = 0; k <= g; k++) begin
          v_q[k] <= 1'b0;
          d_q[k] <= '0;
        end
      end else begin
        v_q[0] <= acc_d;
        d_q[0] <= d_d;
        for (int k = 1; k <= g; k++) begin
          v_q[k] <= v_q[k-1];
          d_q[k] <= d_q[k-1];
        end
      end
    end

    assign lane_en[g]                      = v_q[g];
    assign lane_data[g*DW_DATA +: DW_DATA] = d_q[g];
  end

`ifdef SKEW_ISSUE_STALL_CNT_EN
  logic [W_LEN+7:0] sc_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sc_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      sc_q <= '0;
    end else if (state_q == S_FEED && !in_valid && !(&sc_q)) begin
      sc_q <= sc_q + (W_LEN+8)'(1);
    end
  end

  assign stall_cnt = sc_q;
`endif

endmodule

// File: tb/tb_skew_issue_ctrl.sv
// Directed bench for skew_issue_ctrl with per-lane expectation queues.
// Stall counter checks compile in when SKEW_ISSUE_STALL_CNT_EN is set.
module tb_skew_issue_ctrl;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int WL = 8;

  logic            clk;
  logic            reset_n;
  logic            start;
  logic [WL-1:0]   len;
  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    lane_en;
  logic [N*DW-1:0] lane_data;
  logic            busy;
  logic            done;
`ifdef SKEW_ISSUE_STALL_CNT_EN
  logic [WL+7:0]   stall_cnt;
`endif

  skew_issue_ctrl #(
    .N_LANE (N),
    .DW_DATA(DW),
    .W_LEN  (WL)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .lane_en  (lane_en),
    .lane_data(lane_data),
    .busy     (busy),
    .done     (done)
`ifdef SKEW_ISSUE_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  int          qt [N][$];
  logic [31:0] qd [N][$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic check_lanes();
    logic        e_en;
    logic [31:0] e_d;
    for (int i = 0; i < N; i++) begin
      e_en = 1'b0;
      e_d  = '0;
      if (qt[i].size() > 0 && qt[i][0] == cyc) begin
        e_en = 1'b1;
        e_d  = qd[i][0];
        void'(qt[i].pop_front());
        void'(qd[i].pop_front());
      end
      chk($sformatf("lane_en[%0d]", i), 64'(lane_en[i]), 64'(e_en));
      chk($sformatf("lane_data[%0d]", i),
          64'(lane_data[i*DW +: DW]), 64'(e_d));
    end
  endtask

  task automatic tick(input logic r, input logic b, input logic d);
    @(posedge clk);
    #1;
    cyc++;
    check_lanes();
    chk("in_ready", 64'(in_ready), 64'(r));
    chk("busy", 64'(busy), 64'(b));
    chk("done", 64'(done), 64'(d));
  endtask

  task automatic push_beat(input int beat);
    for (int i = 0; i < N; i++) begin
      in_data[i*DW +: DW] = 32'(16 * beat + i);
      qt[i].push_back(cyc + 1 + i);
      qd[i].push_back(32'(16 * beat + i));
    end
  endtask

  task automatic run_block(input int L, input int bub, input bit ign);
    int acc;
    int f;
    int stalls;
    acc    = 0;
    f      = 0;
    stalls = 0;
    start  = 1'b1;
    len    = WL'(L);
    tick(L > 0, 1'b1, 1'b0);
    start = 1'b0;
    len   = '0;
    if (L == 0) begin
      tick(1'b0, 1'b1, 1'b1);
      tick(1'b0, 1'b0, 1'b0);
    end else begin
      while (acc < L) begin
        start   = ign && (f == 1);
        len     = start ? WL'(7) : WL'(0);
        in_data = '0;
        if (f == bub) begin
          in_valid = 1'b0;
          stalls++;
        end else begin
          in_valid = 1'b1;
          push_beat(acc);
          acc++;
        end
        f++;
        tick(acc < L, 1'b1, 1'b0);
      end
      in_valid = 1'b0;
      in_data  = '0;
      for (int k = 0; k < N - 1; k++) begin
        start = ign && (k == 1);
        len   = start ? WL'(5) : WL'(0);
        tick(1'b0, 1'b1, 1'b0);
      end
      start = 1'b0;
      tick(1'b0, 1'b1, 1'b1);
      tick(1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < N; i++)
      chk($sformatf("pending[%0d]", i), 64'(qt[i].size()), 64'd0);
`ifdef SKEW_ISSUE_STALL_CNT_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(stalls));
`endif
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_lane_en"}, 64'(lane_en), 64'd0);
    chk({tag, "_lane_data"}, 64'(lane_data), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
`ifdef SKEW_ISSUE_STALL_CNT_EN
    chk({tag, "_stall_cnt"}, 64'(stall_cnt), 64'd0);
`endif
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    len      = '0;
    in_valid = 1'b0;
    in_data  = '0;
    #2;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick(1'b0, 1'b0, 1'b0);

    run_block(3, -1, 1'b0);
    run_block(3, 1, 1'b0);
    run_block(0, -1, 1'b0);
    run_block(3, -1, 1'b1);

    start = 1'b1;
    len   = WL'(2);
    tick(1'b1, 1'b1, 1'b0);
    start    = 1'b0;
    len      = '0;
    in_valid = 1'b1;
    push_beat(0);
    tick(1'b1, 1'b1, 1'b0);
    push_beat(1);
    tick(1'b0, 1'b1, 1'b0);
    in_valid = 1'b0;
    in_data  = '0;
    tick(1'b0, 1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    for (int i = 0; i < N; i++) begin
      qt[i].delete();
      qd[i].delete();
    end
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    run_block(3, -1, 1'b0);

    run_block(255, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
